// File: rtl/sfilt_seq_pkg.sv
// Shared types for the sfilt tap sequencer.
// State encoding and the sfilt command codes.
package sfilt_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_SHIFT,
    S_SEND,
    S_WAIT
  } state_t;

  localparam logic [1:0] CMD_FIRST = 2'd0;
  localparam logic [1:0] CMD_MAC   = 2'd1;
  localparam logic [1:0] CMD_SHIFT = 2'd2;
  localparam logic [1:0] CMD_SEND  = 2'd3;

endpackage

// File: rtl/sfilt_seq_hist.sv
// Circular NTAPS-deep sample history.
// Write at wp, read at (wp - off) mod NTAPS.
module sfilt_seq_hist
  import sfilt_seq_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int TAPW  = $clog2(NTAPS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [31:0]     data,
  input  logic            inc,
  input  logic [TAPW-1:0] off,
  output logic [31:0]     rd
);

  localparam logic [TAPW-1:0] LAST = TAPW'(NTAPS - 1);
  localparam logic [TAPW-1:0] NT   = TAPW'(NTAPS);

  logic [31:0]     mem [NTAPS];
  logic [TAPW-1:0] wp;
  logic [TAPW-1:0] idx;

  // modular index; true result always < NTAPS so TAPW-bit wrap is exact
  always_comb begin
    if (off > wp) idx = wp + NT - off;
    else          idx = wp - off;
    rd = mem[idx];
  end

  // sample store and write pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
      wp <= '0;
    end else begin
      if (we) mem[wp] <= data;
      if (inc) wp <= (wp == LAST) ? '0 : wp + 1'b1;
    end
  end

endmodule

// File: rtl/sfilt_seq.sv
// Tap sequencer driving sfilt: FIRST, MACs, SHIFT, SEND, then waits.
// SFSEQ_SHIFT_CFG_EN adds a runtime-writable shift amount.
module sfilt_seq
  import sfilt_seq_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int TAPW  = $clog2(NTAPS),
  parameter int SHIFT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pushin,
  input  logic [31:0]     q,
  output logic            stopin,
  input  logic            coef_we,
  input  logic [TAPW-1:0] coef_addr,
  input  logic [31:0]     coef_data,
`ifdef SFSEQ_SHIFT_CFG_EN
  input  logic            shift_we,
  input  logic [6:0]      shift_val,
`endif
  output logic            f_pushin,
  output logic [1:0]      f_cmd,
  output logic [31:0]     f_q,
  output logic [31:0]     f_h,
  input  logic            f_pushout,
  input  logic [31:0]     f_z,
  output logic            pushout,
  output logic [31:0]     z
);

  localparam logic [TAPW-1:0] LAST = TAPW'(NTAPS - 1);

  state_t          state, nstate;
  logic [TAPW-1:0] tap, ntap;
  logic [31:0]     coef [NTAPS];
  logic [31:0]     hist_rd;
  logic [6:0]      shamt;
  logic            accept, cfg_ok, inc;
  logic            n_fp, n_po;
  logic [1:0]      n_cmd;
  logic [31:0]     n_q, n_h, n_z;

  sfilt_seq_hist #(.NTAPS(NTAPS), .TAPW(TAPW)) u_hist (
    .clk  (clk),
    .rst  (rst),
    .we   (accept),
    .data (q),
    .inc  (inc),
    .off  (tap),
    .rd   (hist_rd)
  );

`ifdef SFSEQ_SHIFT_CFG_EN
  // shift amount register, writable only while idle
  always_ff @(posedge clk) begin
    if (rst)                 shamt <= 7'(SHIFT);
    else if (cfg_ok && shift_we) shamt <= shift_val;
  end
`else
  assign shamt = 7'(SHIFT);
`endif

  // coefficient file, writable only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
    end else if (cfg_ok && coef_we) begin
      coef[coef_addr] <= coef_data;
    end
  end

  // state and tap registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      tap   <= '0;
    end else begin
      state <= nstate;
      tap   <= ntap;
    end
  end

  // next state and next registered outputs
  always_comb begin
    nstate = state;
    ntap   = tap;
    accept = 1'b0;
    cfg_ok = 1'b0;
    inc    = 1'b0;
    n_fp   = 1'b0;
    n_cmd  = CMD_FIRST;
    n_q    = '0;
    n_h    = '0;
    n_po   = 1'b0;
    n_z    = z;
    unique case (state)
      S_IDLE: begin
        cfg_ok = 1'b1;
        if (pushin) begin
          accept = 1'b1;
          ntap   = '0;
          nstate = S_MAC;
        end
      end
      S_MAC: begin
        n_fp  = 1'b1;
        n_cmd = (tap == '0) ? CMD_FIRST : CMD_MAC;
        n_q   = hist_rd;
        n_h   = coef[tap];
        if (tap == LAST) nstate = S_SHIFT;
        else             ntap   = tap + 1'b1;
      end
      S_SHIFT: begin
        n_fp   = 1'b1;
        n_cmd  = CMD_SHIFT;
        n_h    = {25'b0, shamt};
        nstate = S_SEND;
      end
      S_SEND: begin
        n_fp   = 1'b1;
        n_cmd  = CMD_SEND;
        nstate = S_WAIT;
      end
      S_WAIT: begin
        if (f_pushout) begin
          n_po   = 1'b1;
          n_z    = f_z;
          inc    = 1'b1;
          nstate = S_IDLE;
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  // output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stopin   <= 1'b0;
      f_pushin <= 1'b0;
      f_cmd    <= CMD_FIRST;
      f_q      <= '0;
      f_h      <= '0;
      pushout  <= 1'b0;
      z        <= '0;
    end else begin
      stopin   <= (nstate != S_IDLE);
      f_pushin <= n_fp;
      f_cmd    <= n_cmd;
      f_q      <= n_q;
      f_h      <= n_h;
      pushout  <= n_po;
      z        <= n_z;
    end
  end

endmodule

// File: tb/tb_sfilt_seq.sv
// Directed bench for sfilt_seq with a behavioural sfilt.
// Channel 0 runs SHIFT=0, channel 1 runs SHIFT=1 on the same stimulus.
module tb_sfilt_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pushin = 1'b0;
  logic [31:0] q = '0;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_addr = '0;
  logic [31:0] coef_data = '0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : ch
    logic        stopin, f_pushin, pushout, f_pushout;
    logic [1:0]  f_cmd;
    logic [31:0] f_q, f_h, z, f_z;
    logic signed [63:0] acc, prod, rnd;
    logic        pend;
    logic [6:0]  sh;

    sfilt_seq #(.NTAPS(4), .SHIFT(g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .pushin    (pushin),
      .q         (q),
      .stopin    (stopin),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .f_pushin  (f_pushin),
      .f_cmd     (f_cmd),
      .f_q       (f_q),
      .f_h       (f_h),
      .f_pushout (f_pushout),
      .f_z       (f_z),
      .pushout   (pushout),
      .z         (z)
    );

    assign sh   = f_h[6:0];
    assign prod = 64'($signed(f_q)) * 64'($signed(f_h));
    assign rnd  = (sh == 7'd0) ? acc :
                  ((acc + (64'sd1 <<< (sh - 7'd1))) >>> sh);

    // reference sfilt: accumulate, round-shift, emit one cycle after SEND
    always_ff @(posedge clk) begin
      if (rst) begin
        acc <= '0; pend <= 1'b0;
        f_pushout <= 1'b0; f_z <= '0;
      end else begin
        pend <= 1'b0;
        f_pushout <= 1'b0;
        if (pend) begin
          f_pushout <= 1'b1;
          f_z <= acc[31:0];
        end
        if (f_pushin) begin
          case (f_cmd)
            2'd0: acc <= prod;
            2'd1: acc <= acc + prod;
            2'd2: acc <= rnd;
            default: pend <= 1'b1;
          endcase
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pushin = 1'b0;
    coef_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr_coef(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic push(input logic [31:0] s);
    @(negedge clk);
    pushin = 1'b1; q = s;
    @(negedge clk);
    pushin = 1'b0;
  endtask

  task automatic wait_result(output logic [31:0] z0,
                             output logic [31:0] z1,
                             output int npush,
                             output bit ok);
    ok = 1'b0; z0 = '0; z1 = '0; npush = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (ch[0].f_pushin) npush++;
      if (ch[0].pushout) begin
        ok = 1'b1; z0 = ch[0].z; z1 = ch[1].z;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({ch[0].stopin, ch[0].f_pushin, ch[0].pushout, ch[0].f_cmd,
         ch[0].f_q, ch[0].f_h, ch[0].z} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got stopin=%b fp=%b po=%b cmd=%0d q=%h h=%h z=%h want all 0",
               ch[0].stopin, ch[0].f_pushin, ch[0].pushout, ch[0].f_cmd,
               ch[0].f_q, ch[0].f_h, ch[0].z);
    end
  endtask

  task automatic test_fir();
    logic [31:0] z0, z1, exp [3];
    logic [31:0] smp [3];
    int n; bit ok;
    smp = '{32'd10, 32'd20, 32'd30};
    exp = '{32'd10, 32'd40, 32'd100};
    do_reset();
    for (int i = 0; i < 4; i++) wr_coef(2'(i), 32'(i + 1));
    for (int i = 0; i < 3; i++) begin
      push(smp[i]);
      wait_result(z0, z1, n, ok);
      tests_run++;
      if (!ok || z0 !== exp[i]) begin
        tests_failed++;
        $display("FAIL fir_z[%0d] got %0d (ok=%b) want %0d", i, z0, ok, exp[i]);
      end
      tests_run++;
      if (n !== 6) begin
        tests_failed++;
        $display("FAIL fir_cmd_count[%0d] got %0d want 6", i, n);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_shift();
    logic [31:0] z0, z1; int n; bit ok;
    do_reset();
    wr_coef(2'd0, 32'd3);
    push(32'd5);
    wait_result(z0, z1, n, ok);
    tests_run++;
    if (!ok || z1 !== 32'd8) begin
      tests_failed++;
      $display("FAIL shift1_round got %0d want 8", z1);
    end
    tests_run++;
    if (!ok || z0 !== 32'd15) begin
      tests_failed++;
      $display("FAIL shift0 got %0d want 15", z0);
    end
    @(negedge clk);
  endtask

  task automatic test_negative();
    logic [31:0] z0, z1; int n; bit ok;
    do_reset();
    wr_coef(2'd0, 32'd2);
    push(32'hFFFF_FFFC);
    wait_result(z0, z1, n, ok);
    tests_run++;
    if (!ok || z0 !== 32'hFFFF_FFF8) begin
      tests_failed++;
      $display("FAIL negative got %h want fffffff8", z0);
    end
    @(negedge clk);
  endtask

  task automatic test_drop_busy();
    logic [31:0] z0, z1; int n; bit ok;
    do_reset();
    wr_coef(2'd0, 32'd1);
    wr_coef(2'd1, 32'd2);
    push(32'd10);
    wait_result(z0, z1, n, ok);
    @(negedge clk);
    push(32'd20);
    pushin = 1'b1; q = 32'd999;
    tests_run++;
    if (ch[0].stopin !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_stopin got %b want 1", ch[0].stopin);
    end
    @(negedge clk);
    @(negedge clk);
    pushin = 1'b0;
    wait_result(z0, z1, n, ok);
    tests_run++;
    if (!ok || z0 !== 32'd40) begin
      tests_failed++;
      $display("FAIL busy_result got %0d want 40", z0);
    end
    @(negedge clk);
    push(32'd30);
    wait_result(z0, z1, n, ok);
    tests_run++;
    if (!ok || z0 !== 32'd70) begin
      tests_failed++;
      $display("FAIL busy_wp got %0d want 70", z0);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic [31:0] z0, z1; int n; bit ok;
    int seen;
    do_reset();
    wr_coef(2'd0, 32'd1);
    push(32'd100);
    seen = 0;
    for (int i = 0; i < 10 && seen < 2; i++) begin
      if (ch[0].f_pushin) seen++;
      if (seen < 2) @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({ch[0].f_pushin, ch[0].stopin, ch[0].pushout} !== 3'b000 || seen != 2) begin
      tests_failed++;
      $display("FAIL midreset got fp=%b stopin=%b po=%b seen=%0d want 000 seen=2",
               ch[0].f_pushin, ch[0].stopin, ch[0].pushout, seen);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (ch[0].f_pushin !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_quiet got fp=%b want 0", ch[0].f_pushin);
    end
    wr_coef(2'd0, 32'd1);
    push(32'd7);
    wait_result(z0, z1, n, ok);
    tests_run++;
    if (!ok || z0 !== 32'd7) begin
      tests_failed++;
      $display("FAIL midreset_after got %0d want 7", z0);
    end
    @(negedge clk);
  endtask

  task automatic test_coef_busy();
    logic [31:0] z0, z1; int n; bit ok;
    bit sent;
    do_reset();
    wr_coef(2'd0, 32'd5);
    push(32'd1);
    sent = 1'b0;
    for (int i = 0; i < 20 && !sent; i++) begin
      if (ch[0].f_pushin && ch[0].f_cmd == 2'd3) sent = 1'b1;
      else @(negedge clk);
    end
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 32'd9;
    @(negedge clk);
    coef_we = 1'b0;
    wait_result(z0, z1, n, ok);
    tests_run++;
    if (!ok || !sent || z0 !== 32'd5) begin
      tests_failed++;
      $display("FAIL coef_wait_first got %0d sent=%b want 5", z0, sent);
    end
    @(negedge clk);
    push(32'd1);
    wait_result(z0, z1, n, ok);
    tests_run++;
    if (!ok || z0 !== 32'd5) begin
      tests_failed++;
      $display("FAIL coef_wait_ignored got %0d want 5", z0);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fir();
    test_shift();
    test_negative();
    test_drop_busy();
    test_mid_reset();
    test_coef_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
